// File: rtl/instr_fetch_mem_if.sv
// Fetch and program-write bus of the instruction memory; the memory side
// uses the slave modport and the requester uses the master modport.
interface instr_fetch_mem_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic        prog_valid;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_ready;
  logic        init_done;

  modport master (
    output fetch_req, fetch_pc, stall, flush, prog_valid, prog_addr, prog_data,
    input  instr, instr_valid, fetch_fault, prog_ready, init_done
  );

  modport slave (
    input  fetch_req, fetch_pc, stall, flush, prog_valid, prog_addr, prog_data,
    output instr, instr_valid, fetch_fault, prog_ready, init_done
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction memory with 1-cycle big-endian fetch, program-write port
// and post-reset zero sweep. Define IMEM_ALIGN_CHECK_EN to fault unaligned fetches.
module instr_fetch_mem #(
  parameter int          DEPTH_BYTES    = 16384,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_mem_if.slave  bus
);
  localparam int          WORDS     = DEPTH_BYTES / 4;
  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam int          CW        = $clog2(WORDS) + 1;
  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_BYTES - 4);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  clr_cnt;
  logic           clr_we;

  logic [7:0]     mem [DEPTH_BYTES];
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [31:0]    wr_data;

  logic [AW-1:0]  rd_addr;
  logic [31:0]    rd_word;
  logic           rd_fault;
  logic           misaligned;

  logic [31:0]    instr_q;
  logic           instr_valid_q;
  logic           fetch_fault_q;

  // Sweep counter runs one past the last word so RUN starts the cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no inferred latch).
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (clr_cnt == CW'(WORDS)) state_d = RUN;
        else                       clr_we  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.init_done  = (state_q == RUN) && !reset;
  assign bus.prog_ready = (state_q == RUN) && !reset;

  // Out-of-range program writes are accepted via prog_ready but never reach the array.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!reset) begin
      if (clr_we) begin
        wr_en   = 1'b1;
        wr_addr = {clr_cnt[CW-2:0], 2'b00};
      end else if (state_q == RUN && bus.prog_valid && bus.prog_addr <= LAST_ADDR) begin
        wr_en   = 1'b1;
        wr_addr = {bus.prog_addr[AW-1:2], 2'b00};
        wr_data = bus.prog_data;
      end
    end
  end

  // NOTE: the array has no reset; clearing is the explicit sweep in CLEAR.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) mem[wr_addr + AW'(k)] <= wr_data[31-8*k -: 8];
    end
  end

`ifdef IMEM_ALIGN_CHECK_EN
  assign misaligned = (bus.fetch_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Index bits are only meaningful once the range check has passed.
  assign rd_fault = (bus.fetch_pc > LAST_ADDR) || misaligned;
  assign rd_addr  = bus.fetch_pc[AW-1:0];
  assign rd_word  = {mem[rd_addr], mem[rd_addr + AW'(1)],
                     mem[rd_addr + AW'(2)], mem[rd_addr + AW'(3)]};

  // Array read samples pre-edge contents, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else if (bus.flush) begin
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else if (!bus.stall) begin
      if (state_q == RUN && bus.fetch_req) begin
        instr_valid_q <= 1'b1;
        fetch_fault_q <= rd_fault;
        instr_q       <= rd_fault ? NOP_WORD : rd_word;
      end else begin
        instr_valid_q <= 1'b0;
        fetch_fault_q <= 1'b0;
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_fault = fetch_fault_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench: a 64-byte instance for sweep timing and range edges,
// and a default-size instance for fetch, stall, flush, fault and collision behaviour.
module tb_instr_fetch_mem;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_mem_if bs ();
  instr_fetch_mem_if bm ();

  instr_fetch_mem #(.DEPTH_BYTES(64), .NOP_WORD(32'h0), .CLEAR_ON_RESET(1'b1))
    u_small (.clk(clk), .reset(reset), .bus(bs));
  instr_fetch_mem u_main (.clk(clk), .reset(reset), .bus(bm));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    bm.fetch_req = 0; bm.stall = 0; bm.flush = 0; bm.prog_valid = 0;
  endtask

  task automatic prog_main(input logic [31:0] addr, input logic [31:0] data);
    bm.prog_valid = 1; bm.prog_addr = addr; bm.prog_data = data;
    step();
    bm.prog_valid = 0;
  endtask

  task automatic fetch_main(input logic [31:0] pc);
    bm.fetch_req = 1; bm.fetch_pc = pc;
    step();
    bm.fetch_req = 0;
  endtask

  task automatic fetch_small(input logic [31:0] pc);
    bs.fetch_req = 1; bs.fetch_pc = pc;
    step();
    bs.fetch_req = 0;
  endtask

  logic [31:0] unaligned_exp;
  logic        unaligned_fault;
  int          waited;

  initial begin
    bs.fetch_req = 0; bs.fetch_pc = 0; bs.stall = 0; bs.flush = 0;
    bs.prog_valid = 0; bs.prog_addr = 0; bs.prog_data = 0;
    bm.fetch_pc = 0; bm.prog_addr = 0; bm.prog_data = 0;
    idle_main();
    reset = 1;
    step(); step();
    check("rst_instr",   bm.instr, 32'h0);
    check("rst_valid",   32'(bm.instr_valid), 32'd0);
    check("rst_fault",   32'(bm.fetch_fault), 32'd0);
    check("rst_init",    32'(bm.init_done), 32'd0);
    check("rst_pready",  32'(bm.prog_ready), 32'd0);
    reset = 0;

    // Sweep of 16 words: init_done rises on the 17th edge after reset release.
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        bs.prog_valid = 1; bs.prog_addr = 32'd0; bs.prog_data = 32'h1111_1111;
        bs.fetch_req = 1; bs.fetch_pc = 32'd0;
      end
      step();
      if (i == 8) check("clear_fetch_ignored", 32'(bs.instr_valid), 32'd0);
    end
    bs.prog_valid = 0; bs.fetch_req = 0;
    check("init_at_16", 32'(bs.init_done), 32'd0);
    step();
    check("init_at_17",   32'(bs.init_done), 32'd1);
    check("pready_at_17", 32'(bs.prog_ready), 32'd1);

    fetch_small(32'h20);
    check("small_pc20",       bs.instr, 32'h0);
    check("small_pc20_valid", 32'(bs.instr_valid), 32'd1);
    fetch_small(32'h0);
    check("small_clear_prog_ignored", bs.instr, 32'h0);
    fetch_small(32'd60);
    check("small_last_fault", 32'(bs.fetch_fault), 32'd0);
    fetch_small(32'd61);
    check("small_61_fault", 32'(bs.fetch_fault), 32'd1);
    check("small_61_valid", 32'(bs.instr_valid), 32'd1);

    waited = 0;
    while (!bm.init_done && waited < 5000) begin
      step();
      waited++;
    end
    check("main_init_done", 32'(bm.init_done), 32'd1);

    prog_main(32'd100, 32'h4808_0000);
    fetch_main(32'd100);
    check("fetch100",       bm.instr, 32'h4808_0000);
    check("fetch100_valid", 32'(bm.instr_valid), 32'd1);
    step();
    check("idle_hold_instr", bm.instr, 32'h4808_0000);
    check("idle_valid",      32'(bm.instr_valid), 32'd0);

    prog_main(32'd104, 32'h4809_0004);
    fetch_main(32'd104);
    check("fetch104", bm.instr, 32'h4809_0004);
    bm.stall = 1; bm.fetch_req = 1; bm.fetch_pc = 32'd100;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", bm.instr, 32'h4809_0004);
      check("stall_valid", 32'(bm.instr_valid), 32'd1);
    end
    bm.flush = 1;
    step();
    check("flush_instr", bm.instr, 32'h0);
    check("flush_valid", 32'(bm.instr_valid), 32'd0);
    check("flush_fault", 32'(bm.fetch_fault), 32'd0);
    idle_main();

    fetch_main(32'd16384);
    check("oob16384_instr", bm.instr, 32'h0);
    check("oob16384_fault", 32'(bm.fetch_fault), 32'd1);
    check("oob16384_valid", 32'(bm.instr_valid), 32'd1);
    fetch_main(32'd16382);
    check("oob16382_fault", 32'(bm.fetch_fault), 32'd1);
    fetch_main(32'd16380);
    check("last_word_fault", 32'(bm.fetch_fault), 32'd0);
    check("last_word_instr", bm.instr, 32'h0);
    prog_main(32'd16384, 32'hDEAD_BEEF);
    fetch_main(32'd0);
    check("oob_write_discard", bm.instr, 32'h0);

    bm.prog_valid = 1; bm.prog_addr = 32'd200; bm.prog_data = 32'h2413_0005;
    bm.fetch_req = 1; bm.fetch_pc = 32'd200;
    step();
    idle_main();
    check("collide_old", bm.instr, 32'h0);
    fetch_main(32'd200);
    check("collide_new", bm.instr, 32'h2413_0005);

`ifdef IMEM_ALIGN_CHECK_EN
    unaligned_exp   = 32'h0;
    unaligned_fault = 1'b1;
`else
    unaligned_exp   = 32'h0800_0048;
    unaligned_fault = 1'b0;
`endif
    fetch_main(32'd101);
    check("pc101_instr", bm.instr, unaligned_exp);
    check("pc101_fault", 32'(bm.fetch_fault), 32'(unaligned_fault));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
